ps2_box_motion_controller: RTL

Sequencing controller between the PS/2 receive interface and the VGA box overlay. Decodes PS/2 set-2 make/break scan codes for the four arrow keys and W/A/S/D and keeps a held-key state. Once per frame it moves the box position registers, merging the held keys with the board push-buttons and clamping the box to the visible area. Its `box_x`/`box_y` outputs feed the pixel-overlay compare in the VGA top level.

---
 rtl/ps2_box_motion_controller.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_box_motion_controller.sv
// PS/2 arrow/WASD decoder plus per-frame box motion with edge clamping.
// Held-key state is merged with the push-buttons once per frame, and the
// result steps the box's top-left corner while keeping it fully on screen.
module ps2_box_motion_controller #(
  parameter int VIDEO_WIDTH    = 640,
  parameter int VIDEO_HEIGHT   = 480,
  parameter int BOX_SIZE       = 50,
  parameter int STEP           = 1,
  parameter int INIT_X         = 100,
  parameter int INIT_Y         = 100,
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       read_data,
  input  logic       screenEnd,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic [3:0] keys_held,
  output logic       moved
);

  // Held-key bit positions within {up, right, down, left}
  localparam int K_UP    = 3;
  localparam int K_RIGHT = 2;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 0;

  localparam int CNT_W = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  // Motion arithmetic is one bit wider than the coordinates so that
  // position + size + step can never wrap before the limit compare.
  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] SIZE_W  = 11'(BOX_SIZE);
  localparam logic [10:0] X_LIMIT = 11'(VIDEO_WIDTH);
  localparam logic [10:0] Y_LIMIT = 11'(VIDEO_HEIGHT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_t;

  // Set-2 codes of the non-extended letter keys, mapped to held bits
  function automatic logic [3:0] letter_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      8'h1D:   m[K_UP]    = 1'b1;  // W
      8'h1B:   m[K_DOWN]  = 1'b1;  // S
      8'h1C:   m[K_LEFT]  = 1'b1;  // A
      8'h23:   m[K_RIGHT] = 1'b1;  // D
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Set-2 codes of the E0-prefixed arrow keys, mapped to held bits
  function automatic logic [3:0] arrow_mask(input logic [7:0] code);
    logic [3:0] m;
    m = 4'b0000;
    case (code)
      8'h75:   m[K_UP]    = 1'b1;
      8'h72:   m[K_DOWN]  = 1'b1;
      8'h6B:   m[K_LEFT]  = 1'b1;
      8'h74:   m[K_RIGHT] = 1'b1;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Step toward the far edge, clamping so the box stays fully visible
  function automatic logic [9:0] step_inc(input logic [9:0] pos,
                                          input logic [10:0] lim);
    logic [10:0] p;
    p = {1'b0, pos};
    if (p + SIZE_W + STEP_W <= lim) begin
      return 10'(p + STEP_W);
    end
    return 10'(lim - SIZE_W);
  endfunction

  // Step toward zero, clamping at the origin
  function automatic logic [9:0] step_dec(input logic [9:0] pos);
    logic [10:0] p;
    p = {1'b0, pos};
    if (p >= STEP_W) begin
      return 10'(p - STEP_W);
    end
    return 10'd0;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_keys;
  logic [3:0]       w_set;
  logic [3:0]       w_clr;
  logic             r_se_q;
  logic             w_tick;
  logic [3:0]       w_dir;
  logic [9:0]       r_box_x;
  logic [9:0]       r_box_y;
  logic [9:0]       w_x_nxt;
  logic [9:0]       w_y_nxt;
  logic             r_moved;

  // Decoder state, prefix timeout counter and held-key register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_keys  <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_keys  <= (r_keys | w_set) & ~w_clr;
    end
  end

  // Next-state decode: a byte is consumed only in its strobe cycle; a
  // prefix state abandoned by the keyboard falls back to IDLE untouched.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_set       = 4'b0000;
    w_clr       = 4'b0000;
    if (read_data) begin
      w_cnt_nxt = '0;
      case (r_state)
        ST_IDLE: begin
          if (rx_data == 8'hE0) begin
            w_state_nxt = ST_EXT;
          end else if (rx_data == 8'hF0) begin
            w_state_nxt = ST_BRK;
          end else begin
            w_set = letter_mask(rx_data);
          end
        end
        ST_EXT: begin
          if (rx_data == 8'hF0) begin
            w_state_nxt = ST_EXT_BRK;
          end else begin
            w_set       = arrow_mask(rx_data);
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_clr       = letter_mask(rx_data);
          w_state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_clr       = arrow_mask(rx_data);
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE) begin
      if (r_cnt == CNT_LAST) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = r_cnt + 1'b1;
      end
    end else begin
      w_cnt_nxt = '0;
    end
  end

  // Frame-end edge detector: one tick per high period of screenEnd
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_se_q <= 1'b0;
    end else begin
      r_se_q <= screenEnd;
    end
  end

  assign w_tick = screenEnd & ~r_se_q;
  // Uses the registered key state, so a same-cycle strobe waits a frame
  assign w_dir  = r_keys | {btn_up, btn_right, btn_down, btn_left};

  // Per-axis move; opposing directions on one axis cancel out
  always_comb begin
    w_x_nxt = r_box_x;
    w_y_nxt = r_box_y;
    case ({w_dir[K_RIGHT], w_dir[K_LEFT]})
      2'b10:   w_x_nxt = step_inc(r_box_x, X_LIMIT);
      2'b01:   w_x_nxt = step_dec(r_box_x);
      default: w_x_nxt = r_box_x;
    endcase
    case ({w_dir[K_DOWN], w_dir[K_UP]})
      2'b10:   w_y_nxt = step_inc(r_box_y, Y_LIMIT);
      2'b01:   w_y_nxt = step_dec(r_box_y);
      default: w_y_nxt = r_box_y;
    endcase
  end

  // Box position update and moved pulse, once per frame tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_box_x <= 10'(INIT_X);
      r_box_y <= 10'(INIT_Y);
      r_moved <= 1'b0;
    end else if (w_tick) begin
      r_box_x <= w_x_nxt;
      r_box_y <= w_y_nxt;
      r_moved <= (w_x_nxt != r_box_x) || (w_y_nxt != r_box_y);
    end else begin
      r_moved <= 1'b0;
    end
  end

  assign box_x     = r_box_x;
  assign box_y     = r_box_y;
  assign keys_held = r_keys;
  assign moved     = r_moved;

endmodule
